fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer sitting between the program counter and instruction memory.

---
 rtl/fetch_ctrl_if.sv | 38 +++
 rtl/fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the redirect, decode-side and instruction-memory
// signals of the fetch sequencer.
//   slave  : the fetch sequencer (drives imem_req/imem_addr and the if_* slot)
//   master : the surrounding pipeline/memory (drives redirects, stall, ack/rdata)
interface fetch_ctrl_if #(
  parameter int XLEN = 32
);
  // redirect inputs from execute
  logic            redirect_jalr;
  logic [XLEN-1:0] jalr_target;
  logic            redirect_br;
  logic [XLEN-1:0] br_target;
  // decode back-pressure
  logic            stall;
  // instruction memory handshake
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  // output slot towards decode
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport slave (
    input  redirect_jalr, jalr_target, redirect_br, br_target, stall,
    input  imem_ack, imem_rdata,
    output imem_req, imem_addr,
    output if_valid, if_instr, if_pc
  );

  modport master (
    output redirect_jalr, jalr_target, redirect_br, br_target, stall,
    output imem_ack, imem_rdata,
    input  imem_req, imem_addr,
    input  if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the architectural PC, issues one outstanding fetch at a time over a
// req/ack handshake, and presents returned instructions to decode through a
// one-entry output slot backed by a one-entry skid buffer.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous, active-high reset
//   bus  - fetch_ctrl_if.slave: redirects (jalr/br), stall, imem req/addr/ack/rdata,
//          decode slot if_valid/if_instr/if_pc
module fetch_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'hBFC00000)
) (
  input  logic        clk,
  input  logic        rst,
  fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } slot_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pending;   // redirect target waiting for the dropped fetch to finish
  slot_t           out_q;
  logic            out_vld;
  slot_t           skid_q;
  logic            skid_vld;

  logic            redirect;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;
  logic            consume;
  slot_t           fetched;

  // JALR has priority; targets are word aligned by clearing the low bits.
  assign redirect   = bus.redirect_jalr | bus.redirect_br;
  assign target_raw = bus.redirect_jalr ? bus.jalr_target : bus.br_target;
  assign target     = {target_raw[XLEN-1:2], 2'b00};
  assign pc_inc     = pc + XLEN'(4);   // wraps naturally at 2^XLEN
  assign consume    = out_vld & ~bus.stall;
  assign fetched    = '{instr: bus.imem_rdata, pc: pc};

  // Request and address come straight from state/pc, so the address cannot
  // move while a request is waiting for its ack.
  assign bus.imem_req  = (state == FETCH) || (state == DRAIN);
  assign bus.imem_addr = pc;
  assign bus.if_valid  = out_vld;
  assign bus.if_instr  = out_q.instr;
  assign bus.if_pc     = out_q.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_VEC;
      pending  <= '0;
      out_q    <= '0;
      out_vld  <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) pc <= target;
          state <= FETCH;
        end

        FETCH: begin
          if (redirect) begin
            // Flush: whatever is in the slot or returning now is wrong-path.
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            if (bus.imem_ack) begin
              pc <= target;
            end else begin
              // A fetch is in flight; let it complete and discard it.
              pending <= target;
              state   <= DRAIN;
            end
          end else if (bus.imem_ack) begin
            pc <= pc_inc;
            if (!out_vld || consume) begin
              out_q   <= fetched;
              out_vld <= 1'b1;
            end else begin
              skid_q   <= fetched;
              skid_vld <= 1'b1;
              state    <= HOLD;
            end
          end else if (consume) begin
            out_vld <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            pc       <= target;
            state    <= FETCH;
          end else if (!bus.stall) begin
            // Slot is always full in HOLD, so stall=0 means it drains now.
            out_q    <= skid_q;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
            state    <= FETCH;
          end
        end

        DRAIN: begin
          out_vld  <= 1'b0;
          skid_vld <= 1'b0;
          if (redirect) pending <= target;
          if (bus.imem_ack) begin
            // Response is dropped; a same-cycle redirect is the newest target.
            pc    <= redirect ? target : pending;
            state <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  fetch_ctrl_if #(.XLEN(32)) bus ();

  fetch_ctrl #(.XLEN(32), .RESET_VEC(32'hBFC00000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.redirect_jalr = 1'b0;
    bus.jalr_target   = '0;
    bus.redirect_br   = 1'b0;
    bus.br_target     = '0;
    bus.stall         = 1'b0;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
  endtask

  // Assert reset, release it just after an edge; DUT is then in IDLE.
  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++; if (bus.if_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.if_valid); else pass_cnt++;
    total_cnt++; if (bus.if_instr !== 32'h0) $display("FAIL rst_instr: got %h want 00000000", bus.if_instr); else pass_cnt++;
    total_cnt++; if (bus.if_pc !== 32'h0) $display("FAIL rst_pc: got %h want 00000000", bus.if_pc); else pass_cnt++;
    total_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req_cyc1: got %b want 0", bus.imem_req); else pass_cnt++;
    tick();
    total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hBFC00000)
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=bfc00000", bus.imem_req, bus.imem_addr); else pass_cnt++;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00000013;
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h00000013 || bus.if_pc !== 32'hBFC00000)
      $display("FAIL first_instr: got v=%b i=%h pc=%h want v=1 i=00000013 pc=bfc00000", bus.if_valid, bus.if_instr, bus.if_pc); else pass_cnt++;
    total_cnt++; if (bus.imem_addr !== 32'hBFC00004) $display("FAIL next_addr: got %h want bfc00004", bus.imem_addr); else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    apply_reset();
    tick();
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'hBFC00000 + 32'(4 * i);
      bus.imem_rdata = 32'h1000 + 32'(i);
      tick();
      total_cnt++; if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc || bus.if_instr !== 32'h1000 + 32'(i))
        $display("FAIL stream_%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", i, bus.if_valid, bus.if_pc, bus.if_instr, exp_pc, 32'h1000 + 32'(i));
      else pass_cnt++;
    end
    bus.imem_ack = 1'b0;
    tick();
    total_cnt++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'hBFC00010)
      $display("FAIL stream_end: got v=%b addr=%h want v=0 addr=bfc00010", bus.if_valid, bus.imem_addr); else pass_cnt++;
  endtask

  task automatic test_stall();
    apply_reset();
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA0;
    tick();
    bus.stall = 1'b1; bus.imem_rdata = 32'hA4;
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.imem_req !== 1'b0 || bus.if_pc !== 32'hBFC00000 || bus.if_instr !== 32'hA0 || bus.if_valid !== 1'b1)
      $display("FAIL stall_hold: got req=%b v=%b pc=%h i=%h want req=0 v=1 pc=bfc00000 i=000000a0", bus.imem_req, bus.if_valid, bus.if_pc, bus.if_instr);
    else pass_cnt++;
    tick();
    total_cnt++; if (bus.imem_req !== 1'b0 || bus.if_pc !== 32'hBFC00000)
      $display("FAIL stall_hold2: got req=%b pc=%h want req=0 pc=bfc00000", bus.imem_req, bus.if_pc); else pass_cnt++;
    bus.stall = 1'b0;
    tick();
    total_cnt++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hBFC00004 || bus.if_instr !== 32'hA4)
      $display("FAIL stall_release: got v=%b pc=%h i=%h want v=1 pc=bfc00004 i=000000a4", bus.if_valid, bus.if_pc, bus.if_instr); else pass_cnt++;
    total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hBFC00008)
      $display("FAIL stall_next_req: got req=%b addr=%h want req=1 addr=bfc00008", bus.imem_req, bus.imem_addr); else pass_cnt++;
    tick();
    total_cnt++; if (bus.if_valid !== 1'b0) $display("FAIL stall_consumed: got v=%b want 0", bus.if_valid); else pass_cnt++;
  endtask

  task automatic test_drain();
    apply_reset();
    tick();
    bus.imem_ack = 1'b1;
    tick();
    tick();
    bus.imem_ack = 1'b0;
    bus.redirect_br = 1'b1; bus.br_target = 32'hBFC00100;
    tick();
    bus.redirect_br = 1'b0;
    total_cnt++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hBFC00008)
      $display("FAIL drain_enter: got v=%b req=%b addr=%h want v=0 req=1 addr=bfc00008", bus.if_valid, bus.imem_req, bus.imem_addr); else pass_cnt++;
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'hBFC00100)
      $display("FAIL drain_ack: got v=%b addr=%h want v=0 addr=bfc00100", bus.if_valid, bus.imem_addr); else pass_cnt++;
    tick();
    total_cnt++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.if_instr === 32'hDEADBEEF)
      $display("FAIL drain_after: got v=%b req=%b i=%h want v=0 req=1 i!=deadbeef", bus.if_valid, bus.imem_req, bus.if_instr); else pass_cnt++;
  endtask

  task automatic test_priority();
    apply_reset();
    tick();
    bus.imem_ack = 1'b1;
    bus.redirect_jalr = 1'b1; bus.jalr_target = 32'h80000003;
    bus.redirect_br   = 1'b1; bus.br_target   = 32'hBFC00200;
    tick();
    clear_inputs();
    total_cnt++; if (bus.imem_addr !== 32'h80000000 || bus.if_valid !== 1'b0)
      $display("FAIL prio_jalr: got addr=%h v=%b want addr=80000000 v=0", bus.imem_addr, bus.if_valid); else pass_cnt++;
    // two redirects while draining: the later one wins
    bus.redirect_br = 1'b1; bus.br_target = 32'hBFC00300;
    tick();
    bus.redirect_br = 1'b0;
    bus.redirect_jalr = 1'b1; bus.jalr_target = 32'h12345678;
    tick();
    bus.redirect_jalr = 1'b0;
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.imem_addr !== 32'h12345678 || bus.if_valid !== 1'b0)
      $display("FAIL drain_last_wins: got addr=%h v=%b want addr=12345678 v=0", bus.imem_addr, bus.if_valid); else pass_cnt++;
  endtask

  task automatic test_wrap();
    apply_reset();
    tick();
    bus.imem_ack = 1'b1;
    bus.redirect_br = 1'b1; bus.br_target = 32'hFFFFFFFE;
    tick();
    bus.redirect_br = 1'b0;
    total_cnt++; if (bus.imem_addr !== 32'hFFFFFFFC) $display("FAIL wrap_target: got %h want fffffffc", bus.imem_addr); else pass_cnt++;
    bus.imem_rdata = 32'h55;
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.if_pc !== 32'hFFFFFFFC || bus.if_valid !== 1'b1 || bus.imem_addr !== 32'h0)
      $display("FAIL wrap_inc: got pc=%h v=%b addr=%h want pc=fffffffc v=1 addr=00000000", bus.if_pc, bus.if_valid, bus.imem_addr); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    // HOLD case
    apply_reset();
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h11;
    tick();
    bus.stall = 1'b1; bus.imem_rdata = 32'h22;
    tick();
    clear_inputs();
    bus.stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0 || bus.imem_req !== 1'b0)
      $display("FAIL async_hold: got v=%b pc=%h i=%h req=%b want all 0", bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_req); else pass_cnt++;
    tick();
    rst = 1'b0; bus.stall = 1'b0;
    tick();
    total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hBFC00000)
      $display("FAIL async_hold_restart: got req=%b addr=%h want req=1 addr=bfc00000", bus.imem_req, bus.imem_addr); else pass_cnt++;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h33;
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.if_pc !== 32'hBFC00000 || bus.if_instr !== 32'h33)
      $display("FAIL async_hold_first: got pc=%h i=%h want pc=bfc00000 i=00000033", bus.if_pc, bus.if_instr); else pass_cnt++;
    // DRAIN case
    apply_reset();
    tick();
    bus.redirect_br = 1'b1; bus.br_target = 32'hBFC00400;
    tick();
    bus.redirect_br = 1'b0;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0)
      $display("FAIL async_drain: got req=%b v=%b want req=0 v=0", bus.imem_req, bus.if_valid); else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hBFC00000 || bus.imem_addr !== 32'hBFC00004)
      $display("FAIL async_drain_restart: got v=%b pc=%h addr=%h want v=1 pc=bfc00000 addr=bfc00004", bus.if_valid, bus.if_pc, bus.imem_addr); else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_streaming();
    test_stall();
    test_drain();
    test_priority();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
